pkt_injector: RTL and testbench
===============================

Name: pkt_injector

Overview:
- Transmit-side companion to the user-datapath inspection stage: it sources packets into the 64-bit data / 8-bit ctrl stream instead of consuming them.
- Software or CPU logic loads a packet image into a local buffer, then issues a send command for N copies.
- The block inserts those copies between pass-through packets, never inside one.
- It sits in the user data path ahead of the inspection stage and is used for self-test and pattern-match stimulus.

Parameters:
- DATA_WIDTH, 64, stream data width.
- CTRL_WIDTH, DATA_WIDTH/8, stream ctrl width.
- BUF_ADDR_WIDTH, 5, log2 of packet buffer depth (32 words of CTRL_WIDTH+DATA_WIDTH bits).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_data  in  DATA_WIDTH  pass-through stream data.
- in_ctrl  in  CTRL_WIDTH  pass-through stream ctrl.
- in_wr  in  1  pass-through word valid.
- in_rdy  out  1  block accepts pass-through word.
- out_data  out  DATA_WIDTH  merged stream data.
- out_ctrl  out  CTRL_WIDTH  merged stream ctrl.
- out_wr  out  1  merged word valid.
- out_rdy  in  1  downstream ready.
- buf_wr_en  in  1  buffer write strobe.
- buf_wr_addr  in  BUF_ADDR_WIDTH  buffer word index.
- buf_wr_data  in  CTRL_WIDTH+DATA_WIDTH  {ctrl,data} word to store.
- send_start  in  1  one-cycle send command.
- send_len  in  BUF_ADDR_WIDTH+1  words per packet.
- send_copies  in  8  number of copies to send.
- busy  out  1  command accepted and not finished.
- done  out  1  one-cycle pulse after the last word of the last copy.
- tx_pkts  out  32  injected-packet counter.

Behaviour:
- Stream protocol:
  - Word transfers only when out_wr=1; out_wr may only be asserted when out_rdy=1.
  - Packet format: one or more header words with ctrl!=0, then body words with ctrl==0, then a last word with ctrl!=0.
- State machine, states PASS, WAIT_EOP, INJECT:
  - PASS:
    - in_rdy=out_rdy; out_wr=in_wr&&out_rdy; out_* = in_* combinationally (zero latency).
    - A boundary tracker follows pass-through words: hdr phase → body phase on the first ctrl==0 word; body phase → idle after the ctrl!=0 word that follows the body.
  - Command acceptance, only when busy=0:
    - send_start with send_len!=0 and send_copies!=0 latches len (clamped to 2^BUF_ADDR_WIDTH) and copies, and sets busy=1 next cycle.
    - All other send_start pulses are ignored.
  - Leaving PASS when busy=1:
    - Tracker idle (no packet open) → INJECT.
    - Otherwise → WAIT_EOP; it keeps passing words and moves to INJECT the cycle after the accepted end-of-packet word.
  - INJECT:
    - in_rdy=0; out_wr=out_rdy; {out_ctrl,out_data}=buf[ptr] (asynchronous read).
    - Each accepted word increments ptr.
    - Word at ptr==len-1 accepted → ptr=0, tx_pkts+1, copies-1.
    - If copies reach 0 → PASS, busy=0, done=1 for one cycle. Otherwise stay in INJECT for the next copy with no idle cycle.
  - out_rdy=0 in any state: hold ptr/state, out_wr=0.
- Buffer write and contents:
  - buf_wr_en takes effect at the clock edge when busy=0; it is ignored while busy=1.
  - The buffer is not sanity-checked: the loader is responsible for valid ctrl framing.
- tx_pkts: 32-bit, wraps 0xFFFFFFFF→0.
- Simultaneous events:
  - send_start in the same cycle as the done pulse is ignored (busy still 1).
  - buf_wr_en in the same cycle as an accepted send_start is ignored.
- Reset values: state=PASS, busy=0, done=0, tx_pkts=0, ptr=0, copies=0, tracker idle.
  - Combinational outputs follow the PASS equations.
  - Buffer contents are not cleared.
  - Reset mid-INJECT abandons the partial packet immediately; downstream sees a truncated packet (accepted behaviour).

Decomposition:
- Shared package holds:
  - state encodings PASS/WAIT_EOP/INJECT;
  - the ctrl-framing constants CTRL_BODY=0;
  - the BUF_ADDR_WIDTH default.
- One natural sub-module: pkt_boundary_tracker. It takes ctrl/wr/rdy and outputs pkt_open and eop_accepted.
  - The inspection stage can reuse it.

Test Plan:
- Load 4 words (ctrl FF,00,00,01), send_len=4, send_copies=1, no input traffic → out_wr on 4 consecutive cycles with exact buffer words, done pulse, tx_pkts=1, busy=0.
- Pass-through packet of 6 words in progress; send_start after word 2 → all 6 words pass unmodified, injected packet starts the cycle after word 6, in_rdy=0 during injection.
- send_copies=3, len=4, out_rdy toggled 1/0 every cycle → exactly 12 words, no duplicates/skips, tx_pkts=3, single done pulse.
- send_len=0 or send_copies=0, or send_start while busy → ignored, busy unchanged, no out_wr from buffer.
- buf_wr_en while busy changing word 1 → injected word 1 still the old value; after done, the write succeeds.
- Reset asserted mid-INJECT at word 2 → next cycle state=PASS, busy=0, tx_pkts=0, in_rdy follows out_rdy.

Source files
------------

// File: rtl/pkt_injector_pkg.sv
// Shared definitions for the packet injector and its boundary tracker.
package pkt_injector_pkg;

  // Default packet buffer depth is 2**5 = 32 words
  localparam int BUF_ADDR_WIDTH_DEFAULT = 5;

  // ctrl value carried by packet body words; anything else is header or end-of-packet
  localparam int CTRL_BODY = 0;

  // Injector control states
  typedef enum logic [1:0] {
    PASS     = 2'd0,
    WAIT_EOP = 2'd1,
    INJECT   = 2'd2
  } inj_state_t;

  // Position of the boundary tracker within a pass-through packet
  typedef enum logic [1:0] {
    TRK_IDLE = 2'd0,
    TRK_HDR  = 2'd1,
    TRK_BODY = 2'd2
  } trk_phase_t;

endpackage

// File: rtl/pkt_boundary_tracker.sv
// Follows accepted stream words and reports whether a packet is currently open
// and whether the word transferring this cycle closes a packet.
module pkt_boundary_tracker
  import pkt_injector_pkg::*;
#(
  parameter int CTRL_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CTRL_WIDTH-1:0] ctrl,
  input  logic                  wr,
  input  logic                  rdy,
  output logic                  pkt_open,
  output logic                  eop_accepted
);

  trk_phase_t phase;
  logic       xfer;
  logic       is_body;

  assign xfer         = wr && rdy;
  assign is_body      = (ctrl == CTRL_WIDTH'(CTRL_BODY));
  assign pkt_open     = (phase != TRK_IDLE);
  assign eop_accepted = xfer && (phase == TRK_BODY) && !is_body;

  // Advance header -> body -> idle on each accepted word; stray body words while idle are ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= TRK_IDLE;
    end else if (xfer) begin
      case (phase)
        TRK_IDLE: if (!is_body) phase <= TRK_HDR;
        TRK_HDR:  if (is_body)  phase <= TRK_BODY;
        TRK_BODY: if (!is_body) phase <= TRK_IDLE;
        default:                phase <= TRK_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pkt_injector.sv
// Merges buffered packet copies into a pass-through 64-bit stream, only at packet boundaries.
module pkt_injector
  import pkt_injector_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int CTRL_WIDTH     = DATA_WIDTH / 8,
  parameter int BUF_ADDR_WIDTH = BUF_ADDR_WIDTH_DEFAULT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic [CTRL_WIDTH-1:0]            in_ctrl,
  input  logic                             in_wr,
  output logic                             in_rdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  input  logic                             buf_wr_en,
  input  logic [BUF_ADDR_WIDTH-1:0]        buf_wr_addr,
  input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] buf_wr_data,
  input  logic                             send_start,
  input  logic [BUF_ADDR_WIDTH:0]          send_len,
  input  logic [7:0]                       send_copies,
  output logic                             busy,
  output logic                             done,
  output logic [31:0]                      tx_pkts
);

  localparam int DEPTH = 1 << BUF_ADDR_WIDTH;
  localparam int LW    = BUF_ADDR_WIDTH + 1;
  localparam int WW    = CTRL_WIDTH + DATA_WIDTH;

  logic [WW-1:0]             buf_mem [DEPTH];
  inj_state_t                state;
  logic                      busy_reg;
  logic                      done_reg;
  logic [BUF_ADDR_WIDTH-1:0] ptr;
  logic [LW-1:0]             len;
  logic [7:0]                copies;
  logic [31:0]               tx_cnt;

  logic                      pkt_open;
  logic                      eop_accepted;
  logic                      cmd_accept;
  logic [LW-1:0]             len_clamped;
  logic                      last_word;
  logic                      opening;
  logic [WW-1:0]             rd_word;

  // busy stays high through the done cycle so a command or buffer write there is refused
  assign busy    = busy_reg || done_reg;
  assign done    = done_reg;
  assign tx_pkts = tx_cnt;

  assign cmd_accept  = send_start && !busy && (send_len != '0) && (send_copies != '0);
  assign len_clamped = (send_len > LW'(DEPTH)) ? LW'(DEPTH) : send_len;
  assign last_word   = ({1'b0, ptr} == (len - LW'(1)));
  assign rd_word     = buf_mem[ptr];
  assign opening     = in_wr && in_rdy && !pkt_open && (in_ctrl != CTRL_WIDTH'(CTRL_BODY));

  pkt_boundary_tracker #(
    .CTRL_WIDTH(CTRL_WIDTH)
  ) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .ctrl        (in_ctrl),
    .wr          (in_wr),
    .rdy         (in_rdy),
    .pkt_open    (pkt_open),
    .eop_accepted(eop_accepted)
  );

  // Output mux: zero-latency pass-through, or the buffer word at ptr while injecting
  always_comb begin
    in_rdy   = out_rdy;
    out_wr   = in_wr && out_rdy;
    out_data = in_data;
    out_ctrl = in_ctrl;
    if (state == INJECT) begin
      in_rdy               = 1'b0;
      out_wr               = out_rdy;
      {out_ctrl, out_data} = rd_word;
    end
  end

  // Packet buffer; contents survive reset and are frozen while a command is active
  always_ff @(posedge clk) begin
    if (buf_wr_en && !busy && !cmd_accept) begin
      buf_mem[buf_wr_addr] <= buf_wr_data;
    end
  end

  // Command latch, boundary-aware state machine and copy/word sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PASS;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      ptr      <= '0;
      len      <= '0;
      copies   <= '0;
      tx_cnt   <= '0;
    end else begin
      done_reg <= 1'b0;
      if (cmd_accept) begin
        len      <= len_clamped;
        copies   <= send_copies;
        busy_reg <= 1'b1;
      end
      case (state)
        PASS: begin
          if (busy_reg) begin
            if ((pkt_open && !eop_accepted) || opening) state <= WAIT_EOP;
            else                                        state <= INJECT;
          end
        end
        WAIT_EOP: begin
          if (eop_accepted) state <= INJECT;
        end
        INJECT: begin
          if (out_rdy) begin
            if (last_word) begin
              ptr    <= '0;
              tx_cnt <= tx_cnt + 32'd1;
              copies <= copies - 8'd1;
              if (copies == 8'd1) begin
                state    <= PASS;
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
              end
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: state <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_injector.sv
// Scoreboard bench for pkt_injector: stimulus pushes expected stream words, a monitor pops them.
module tb_pkt_injector;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int AW = 5;
  localparam int WW = CW + DW;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_wr;
  logic          in_rdy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_wr;
  logic          out_rdy;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic [WW-1:0] buf_wr_data;
  logic          send_start;
  logic [AW:0]   send_len;
  logic [7:0]    send_copies;
  logic          busy;
  logic          done;
  logic [31:0]   tx_pkts;

  int            total = 0;
  int            bad = 0;
  int            done_seen = 0;
  logic [WW-1:0] exp_q [$];
  logic [WW-1:0] model_buf [32];
  logic [WW-1:0] mon_exp;

  pkt_injector #(
    .DATA_WIDTH(DW),
    .CTRL_WIDTH(CW),
    .BUF_ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .in_wr      (in_wr),
    .in_rdy     (in_rdy),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .out_wr     (out_wr),
    .out_rdy    (out_rdy),
    .buf_wr_en  (buf_wr_en),
    .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data),
    .send_start (send_start),
    .send_len   (send_len),
    .send_copies(send_copies),
    .busy       (busy),
    .done       (done),
    .tx_pkts    (tx_pkts)
  );

  always #5 clk = ~clk;

  // Monitor: every presented output word must match the head of the expected queue
  always @(negedge clk) begin
    if (out_wr) begin
      total++;
      if (!out_rdy) begin
        bad++;
        $display("[TB] FAIL out_wr_without_rdy: got out_wr=1 out_rdy=0 expected out_wr=0");
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_word: got %h expected no word", {out_ctrl, out_data});
      end else begin
        mon_exp = exp_q.pop_front();
        if ({out_ctrl, out_data} !== mon_exp) begin
          bad++;
          $display("[TB] FAIL stream_word: got %h expected %h", {out_ctrl, out_data}, mon_exp);
        end
      end
    end
    if (done) done_seen++;
  end

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One buffer write cycle; the model only tracks writes the block is expected to take
  task automatic loadWord(input int addr, input logic [WW-1:0] word, input bit take);
    buf_wr_en   = 1'b1;
    buf_wr_addr = AW'(addr);
    buf_wr_data = word;
    if (take) model_buf[addr] = word;
    stepClock();
    buf_wr_en = 1'b0;
  endtask

  task automatic pushCopies(input int len, input int copies);
    for (int c = 0; c < copies; c++)
      for (int i = 0; i < len; i++) exp_q.push_back(model_buf[i]);
  endtask

  // One send_start cycle, optionally with a simultaneous buffer write
  task automatic applyStimulus(input int len, input int copies, input bit wr_en,
                               input int wr_addr, input logic [WW-1:0] wr_data);
    send_start  = 1'b1;
    send_len    = (AW + 1)'(len);
    send_copies = 8'(copies);
    buf_wr_en   = wr_en;
    buf_wr_addr = AW'(wr_addr);
    buf_wr_data = wr_data;
    stepClock();
    send_start = 1'b0;
    buf_wr_en  = 1'b0;
  endtask

  task automatic waitDone(input string name, input bit toggle_rdy);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (toggle_rdy) out_rdy = ~out_rdy;
      stepClock();
      if (done) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL %s: got no done pulse expected done within 200 cycles", name);
    end
    out_rdy = 1'b1;
  endtask

  initial begin
    int d0;
    reset = 1'b1; in_data = '0; in_ctrl = '0; in_wr = 1'b0; out_rdy = 1'b1;
    buf_wr_en = 1'b0; buf_wr_addr = '0; buf_wr_data = '0;
    send_start = 1'b0; send_len = '0; send_copies = '0;
    stepClock();
    stepClock();
    $display("[TB] reset state");
    checkOutput("reset_busy", WW'(busy), WW'(0));
    checkOutput("reset_done", WW'(done), WW'(0));
    checkOutput("reset_tx", WW'(tx_pkts), WW'(0));
    checkOutput("reset_in_rdy", WW'(in_rdy), WW'(1));
    reset = 1'b0;
    stepClock();

    $display("[TB] single copy, idle input");
    loadWord(0, {8'hFF, 64'hA0A0_0000_0000_0000}, 1'b1);
    loadWord(1, {8'h00, 64'hA1A1_1111_1111_1111}, 1'b1);
    loadWord(2, {8'h00, 64'hA2A2_2222_2222_2222}, 1'b1);
    loadWord(3, {8'h01, 64'hA3A3_3333_3333_3333}, 1'b1);
    d0 = done_seen;
    pushCopies(4, 1);
    applyStimulus(4, 1, 1'b0, 0, '0);
    checkOutput("t1_busy_set", WW'(busy), WW'(1));
    waitDone("t1_done", 1'b0);
    checkOutput("t1_tx", WW'(tx_pkts), WW'(1));
    stepClock();
    checkOutput("t1_busy_clear", WW'(busy), WW'(0));
    checkOutput("t1_done_count", WW'(done_seen - d0), WW'(1));
    checkOutput("t1_drained", WW'(exp_q.size()), WW'(0));

    $display("[TB] injection waits for pass-through end of packet");
    for (int k = 0; k < 6; k++) begin
      in_wr   = 1'b1;
      in_ctrl = (k == 0) ? 8'hFF : (k == 5) ? 8'h03 : 8'h00;
      in_data = 64'h1111_0000_0000_0000 | 64'(k);
      exp_q.push_back({in_ctrl, in_data});
      if (k == 5) pushCopies(4, 1);
      if (k == 2) begin
        send_start = 1'b1; send_len = 6'd4; send_copies = 8'd1;
      end
      stepClock();
      send_start = 1'b0;
    end
    in_wr = 1'b0;
    checkOutput("t2_in_rdy_inject", WW'(in_rdy), WW'(0));
    checkOutput("t2_first_inject_wr", WW'(out_wr), WW'(1));
    checkOutput("t2_first_inject_word", {out_ctrl, out_data}, model_buf[0]);
    waitDone("t2_done", 1'b0);
    checkOutput("t2_tx", WW'(tx_pkts), WW'(2));
    stepClock();
    checkOutput("t2_drained", WW'(exp_q.size()), WW'(0));

    $display("[TB] three copies with toggling out_rdy");
    d0 = done_seen;
    pushCopies(4, 3);
    applyStimulus(4, 3, 1'b0, 0, '0);
    waitDone("t3_done", 1'b1);
    for (int n = 0; n < 3; n++) stepClock();
    checkOutput("t3_tx", WW'(tx_pkts), WW'(5));
    checkOutput("t3_done_count", WW'(done_seen - d0), WW'(1));
    checkOutput("t3_drained", WW'(exp_q.size()), WW'(0));

    $display("[TB] ignored commands");
    applyStimulus(0, 2, 1'b0, 0, '0);
    checkOutput("t4_len0_busy", WW'(busy), WW'(0));
    applyStimulus(4, 0, 1'b0, 0, '0);
    checkOutput("t4_copies0_busy", WW'(busy), WW'(0));
    for (int n = 0; n < 3; n++) stepClock();
    checkOutput("t4_idle_out_wr", WW'(out_wr), WW'(0));
    pushCopies(4, 2);
    applyStimulus(4, 2, 1'b0, 0, '0);
    stepClock();
    applyStimulus(4, 1, 1'b0, 0, '0);
    checkOutput("t4_busy_held", WW'(busy), WW'(1));
    waitDone("t4_done", 1'b0);
    for (int n = 0; n < 4; n++) stepClock();
    checkOutput("t4_tx", WW'(tx_pkts), WW'(7));
    checkOutput("t4_drained", WW'(exp_q.size()), WW'(0));

    $display("[TB] buffer writes while busy");
    pushCopies(4, 1);
    applyStimulus(4, 1, 1'b1, 2, {8'h00, 64'hBAD2_BAD2_BAD2_BAD2});
    loadWord(1, {8'h00, 64'hBAD1_BAD1_BAD1_BAD1}, 1'b0);
    waitDone("t5_done_a", 1'b0);
    stepClock();
    loadWord(1, {8'h00, 64'hC1C1_C1C1_C1C1_C1C1}, 1'b1);
    pushCopies(4, 1);
    applyStimulus(4, 1, 1'b0, 0, '0);
    waitDone("t5_done_b", 1'b0);
    stepClock();
    checkOutput("t5_tx", WW'(tx_pkts), WW'(9));
    checkOutput("t5_drained", WW'(exp_q.size()), WW'(0));

    $display("[TB] reset during injection");
    exp_q.push_back(model_buf[0]);
    exp_q.push_back(model_buf[1]);
    exp_q.push_back(model_buf[2]);
    applyStimulus(4, 2, 1'b0, 0, '0);
    stepClock();
    stepClock();
    stepClock();
    checkOutput("t6_word2_shown", {out_ctrl, out_data}, model_buf[2]);
    reset = 1'b1;
    stepClock();
    reset = 1'b0;
    checkOutput("t6_busy", WW'(busy), WW'(0));
    checkOutput("t6_tx", WW'(tx_pkts), WW'(0));
    checkOutput("t6_out_wr", WW'(out_wr), WW'(0));
    out_rdy = 1'b0;
    #1;
    checkOutput("t6_in_rdy_low", WW'(in_rdy), WW'(0));
    out_rdy = 1'b1;
    #1;
    checkOutput("t6_in_rdy_high", WW'(in_rdy), WW'(1));
    for (int n = 0; n < 4; n++) stepClock();
    checkOutput("t6_drained", WW'(exp_q.size()), WW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
